medir_dht11_multi: RTL and testbench

//  Next-generation DHT11 reader: polls NUM_SENSORES single-wire DHT11 buses in sequence with one shared protocol engine.

---
 rtl/medir_dht11_multi.sv | 245 ++++++++++++++++++++++++
 tb/tb_medir_dht11_multi.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/medir_dht11_multi.sv
// medir_dht11_multi: polls several single-wire DHT11 buses in turn with one shared
// protocol engine, retrying each channel and keeping per-channel results.
module medir_dht11_multi #(
  parameter int unsigned NUM_SENSORES   = 4,
  parameter int unsigned MAX_TENTATIVAS = 3,
  parameter int unsigned T_START        = 900_000,
  parameter int unsigned T_LIMIAR       = 2_000,
  parameter int unsigned T_TIMEOUT_FASE = 5_000,
  parameter int unsigned T_REPOUSO      = 50_000,
  parameter int unsigned PERIODO        = 50_000_000
) (
  input  logic                        clock,
  input  logic                        reset,
  inout  wire  [NUM_SENSORES-1:0]     dht_bus,
  input  logic                        medir,
  input  logic                        modo_continuo,
  output logic [16*NUM_SENSORES-1:0]  umidade,
  output logic [16*NUM_SENSORES-1:0]  temperatura,
  output logic [NUM_SENSORES-1:0]     valido,
  output logic [NUM_SENSORES-1:0]     erro_canal,
  output logic                        ocupado,
  output logic                        pronto,
  output logic [3:0]                  db_estado
);

  localparam int unsigned CW = (NUM_SENSORES > 1) ? $clog2(NUM_SENSORES) : 1;

  typedef enum logic [3:0] {
    StOcioso     = 4'd0,
    StRepouso    = 4'd1,
    StStart      = 4'd2,
    StEsperaResp = 4'd3,
    StRespBaixo  = 4'd4,
    StRespAlto   = 4'd5,
    StBitBaixo   = 4'd6,
    StBitAlto    = 4'd7,
    StVerifica   = 4'd8,
    StRegistra   = 4'd9,
    StFalha      = 4'd10,
    StProximo    = 4'd11
  } estado_t;

  estado_t                 estado;
  logic [CW-1:0]           canal;
  logic [3:0]              tentativas;
  logic [31:0]             cnt;
  logic [5:0]              nbits;
  logic [39:0]             dados;
  logic                    drive_low;
  logic [31:0]             per_cnt;
  logic                    per_pend;
  logic [NUM_SENSORES-1:0] sync1, sync2, sync3;

  logic       linha, linha_ant, queda, subida;
  logic       tempo_esgotado, periodo_fim, inicio, ultimo, soma_ok;
  logic [7:0] soma;

  // Open-drain drivers: only the selected channel is ever pulled low.
  for (genvar i = 0; i < NUM_SENSORES; i++) begin : g_bus
    assign dht_bus[i] = (drive_low && (canal == CW'(i))) ? 1'b0 : 1'bz;
  end

  // Two-FF synchroniser per bus plus one extra stage for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
      sync3 <= '1;
    end else begin
      sync1 <= dht_bus;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Edge detection on the selected channel, checksum and scan-start decode.
  always_comb begin
    linha          = sync2[canal];
    linha_ant      = sync3[canal];
    queda          = linha_ant & ~linha;
    subida         = ~linha_ant & linha;
    tempo_esgotado = (cnt >= T_TIMEOUT_FASE - 1);
    periodo_fim    = (per_cnt == PERIODO - 1);
    inicio         = (estado == StOcioso) &&
                     (medir || (modo_continuo && (per_pend || periodo_fim)));
    ultimo         = (32'(canal) == NUM_SENSORES - 1);
    soma           = dados[39:32] + dados[31:24] + dados[23:16] + dados[15:8];
    soma_ok        = (soma == dados[7:0]);
  end

  // Continuous-mode period counter; an expiry during a scan is held until OCIOSO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      per_cnt  <= '0;
      per_pend <= 1'b0;
    end else if (!modo_continuo || inicio) begin
      per_cnt  <= '0;
      per_pend <= 1'b0;
    end else if (periodo_fim) begin
      per_cnt  <= '0;
      per_pend <= 1'b1;
    end else begin
      per_cnt <= per_cnt + 32'd1;
    end
  end

  // Protocol engine, retry/channel sequencing and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= StOcioso;
      canal       <= '0;
      tentativas  <= '0;
      cnt         <= '0;
      nbits       <= '0;
      dados       <= '0;
      drive_low   <= 1'b0;
      ocupado     <= 1'b0;
      pronto      <= 1'b0;
      umidade     <= '0;
      temperatura <= '0;
      valido      <= '0;
      erro_canal  <= '0;
    end else begin
      pronto <= 1'b0;
      cnt    <= cnt + 32'd1;
      case (estado)
        StOcioso: begin
          cnt <= '0;
          if (inicio) begin
            canal      <= '0;
            tentativas <= '0;
            ocupado    <= 1'b1;
            erro_canal <= '0;
            estado     <= StRepouso;
          end
        end
        StRepouso: begin
          if (cnt >= T_REPOUSO - 1) begin
            cnt       <= '0;
            nbits     <= '0;
            dados     <= '0;
            drive_low <= 1'b1;
            estado    <= StStart;
          end
        end
        StStart: begin
          if (cnt >= T_START - 1) begin
            cnt       <= '0;
            drive_low <= 1'b0;
            estado    <= StEsperaResp;
          end
        end
        StEsperaResp: begin
          // Falling edge, not low level: the synchroniser still holds our own start pulse.
          if (queda) begin
            cnt    <= '0;
            estado <= StRespBaixo;
          end else if (tempo_esgotado) begin
            cnt    <= '0;
            estado <= StFalha;
          end
        end
        StRespBaixo: begin
          if (subida) begin
            cnt    <= '0;
            estado <= StRespAlto;
          end else if (tempo_esgotado) begin
            cnt    <= '0;
            estado <= StFalha;
          end
        end
        StRespAlto: begin
          if (queda) begin
            cnt    <= '0;
            estado <= StBitBaixo;
          end else if (tempo_esgotado) begin
            cnt    <= '0;
            estado <= StFalha;
          end
        end
        StBitBaixo: begin
          // The rising-edge cycle is already one high sample, so the count starts at 1.
          if (subida) begin
            cnt    <= 32'd1;
            estado <= StBitAlto;
          end else if (tempo_esgotado) begin
            cnt    <= '0;
            estado <= StFalha;
          end
        end
        StBitAlto: begin
          if (queda) begin
            dados <= {dados[38:0], (cnt > T_LIMIAR)};
            cnt   <= '0;
            if (nbits == 6'd39) begin
              estado <= StVerifica;
            end else begin
              nbits  <= nbits + 6'd1;
              estado <= StBitBaixo;
            end
          end else if (tempo_esgotado) begin
            cnt    <= '0;
            estado <= StFalha;
          end
        end
        StVerifica: begin
          estado <= soma_ok ? StRegistra : StFalha;
        end
        StRegistra: begin
          umidade[16*canal +: 16]     <= dados[39:24];
          temperatura[16*canal +: 16] <= dados[23:8];
          valido[canal]               <= 1'b1;
          erro_canal[canal]           <= 1'b0;
          estado                      <= StProximo;
        end
        StFalha: begin
          cnt <= '0;
          if (32'(tentativas) + 32'd1 < MAX_TENTATIVAS) begin
            tentativas <= tentativas + 4'd1;
            estado     <= StRepouso;
          end else begin
            erro_canal[canal] <= 1'b1;
            estado            <= StProximo;
          end
        end
        StProximo: begin
          cnt <= '0;
          if (ultimo) begin
            pronto  <= 1'b1;
            ocupado <= 1'b0;
            estado  <= StOcioso;
          end else begin
            canal      <= canal + 1'b1;
            tentativas <= '0;
            estado     <= StRepouso;
          end
        end
        default: estado <= StOcioso;
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_medir_dht11_multi.sv
// tb_medir_dht11_multi: directed scenarios against behavioural DHT11 sensor models.
module tb_medir_dht11_multi;

  logic        clock = 1'b0;
  logic        reset;
  logic        medir;
  logic        modo_continuo;
  wire  [1:0]  dht_bus;
  logic [31:0] umidade, temperatura;
  logic [1:0]  valido, erro_canal;
  logic        ocupado, pronto;
  logic [3:0]  db_estado;

  int checks = 0;
  int errors = 0;

  // Sensor model state: drv written only by the sensor process, the rest by the main process.
  logic [1:0]  drv;
  logic        abort = 1'b0;
  logic        silent [2] = '{1'b0, 1'b0};
  logic [39:0] dat [2];
  int          bad_ate [2] = '{0, 0};
  int          starts [2] = '{0, 0};
  int          hz0 = 4;
  int          hz1 = 12;

  pullup (dht_bus[0]);
  pullup (dht_bus[1]);
  assign dht_bus[0] = drv[0] ? 1'b0 : 1'bz;
  assign dht_bus[1] = drv[1] ? 1'b0 : 1'bz;

  medir_dht11_multi #(
    .NUM_SENSORES  (2),
    .MAX_TENTATIVAS(3),
    .T_START       (20),
    .T_LIMIAR      (8),
    .T_TIMEOUT_FASE(40),
    .T_REPOUSO     (10),
    .PERIODO       (2000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .dht_bus      (dht_bus),
    .medir        (medir),
    .modo_continuo(modo_continuo),
    .umidade      (umidade),
    .temperatura  (temperatura),
    .valido       (valido),
    .erro_canal   (erro_canal),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  task automatic hold(input int ch, input logic low, input int n);
    for (int k = 0; k < n; k++) begin
      if (abort) break;
      drv = low ? (2'b01 << ch) : 2'b00;
      @(negedge clock);
    end
  endtask

  task automatic respond(input int ch);
    logic [39:0] d;
    d = dat[ch];
    if (starts[ch] <= bad_ate[ch]) d[7:0] = d[7:0] ^ 8'hFF;
    hold(ch, 1'b0, 3);
    hold(ch, 1'b1, 8);
    hold(ch, 1'b0, 8);
    for (int b = 39; b >= 0; b--) begin
      hold(ch, 1'b1, 6);
      hold(ch, 1'b0, d[b] ? hz1 : hz0);
    end
    hold(ch, 1'b1, 6);
    drv = 2'b00;
  endtask

  // Sensor: wait for a host start pulse on either bus, then answer on that bus.
  initial begin : sensor
    int ch;
    int n;
    drv = 2'b00;
    forever begin
      @(negedge clock);
      if (drv == 2'b00 && reset === 1'b1 && dht_bus != 2'b11) begin
        ch = dht_bus[0] ? 1 : 0;
        starts[ch] = starts[ch] + 1;
        n = 0;
        while (dht_bus[ch] == 1'b0 && n < 200) begin
          @(negedge clock);
          n++;
        end
        if (!silent[ch] && !abort && reset) respond(ch);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    medir = 1'b0;
    modo_continuo = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Pulse medir and wait (bounded) for the scan to end; counts pronto pulses.
  task automatic run_scan(output int npr, output logic fin);
    npr = 0;
    fin = 1'b0;
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if (pronto) npr++;
      if (!ocupado) begin
        fin = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (umidade !== 32'h0) begin errors++; $display("FAIL reset_umidade got %h exp 0", umidade); end
    checks++; if (temperatura !== 32'h0) begin errors++; $display("FAIL reset_temperatura got %h exp 0", temperatura); end
    checks++; if (valido !== 2'b00 || erro_canal !== 2'b00) begin errors++; $display("FAIL reset_flags got %b/%b exp 00/00", valido, erro_canal); end
    checks++; if (ocupado !== 1'b0 || pronto !== 1'b0) begin errors++; $display("FAIL reset_status got %b%b exp 00", ocupado, pronto); end
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado got %0d exp 0", db_estado); end
    checks++; if (dht_bus !== 2'b11) begin errors++; $display("FAIL reset_bus got %b exp 11", dht_bus); end
  endtask

  task automatic test_silent();
    int s0, s1, t_rel, nf, npr;
    logic p0, fin;
    logic [3:0] pe;
    silent[0] = 1'b1; silent[1] = 1'b0;
    dat[1] = 40'h41011B025F;
    bad_ate[0] = starts[0]; bad_ate[1] = starts[1];
    s0 = starts[0]; s1 = starts[1];
    t_rel = 0; nf = 0; npr = 0; fin = 1'b0;
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    p0 = dht_bus[0];
    pe = db_estado;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clock);
      if (!p0 && dht_bus[0]) t_rel = k;
      if (db_estado == 4'd10 && pe != 4'd10 && nf < 3) begin
        checks++;
        if (k - t_rel !== 40) begin errors++; $display("FAIL silent_timeout%0d got %0d exp 40", nf, k - t_rel); end
        nf++;
      end
      if (pronto) npr++;
      if (!ocupado) begin fin = 1'b1; break; end
      p0 = dht_bus[0];
      pe = db_estado;
    end
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL silent_done got %b exp 1", fin); end
    checks++; if (nf !== 3) begin errors++; $display("FAIL silent_failures got %0d exp 3", nf); end
    checks++; if (starts[0] - s0 !== 3 || starts[1] - s1 !== 1) begin errors++; $display("FAIL silent_starts got %0d/%0d exp 3/1", starts[0] - s0, starts[1] - s1); end
    checks++; if (erro_canal !== 2'b01 || valido !== 2'b10) begin errors++; $display("FAIL silent_flags got %b/%b exp 01/10", erro_canal, valido); end
    checks++; if (umidade !== 32'h41010000 || temperatura !== 32'h1B020000) begin errors++; $display("FAIL silent_data got %h/%h exp 41010000/1b020000", umidade, temperatura); end
    checks++; if (npr !== 1) begin errors++; $display("FAIL silent_pronto got %0d exp 1", npr); end
  endtask

  task automatic test_scan_ok();
    int s0, s1, npr;
    logic fin;
    silent[0] = 1'b0; silent[1] = 1'b0;
    dat[0] = 40'h3700190555; dat[1] = 40'h3700190555;
    bad_ate[0] = starts[0]; bad_ate[1] = starts[1];
    s0 = starts[0]; s1 = starts[1];
    run_scan(npr, fin);
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL scan_done got %b exp 1", fin); end
    checks++; if (umidade !== 32'h37003700) begin errors++; $display("FAIL scan_umidade got %h exp 37003700", umidade); end
    checks++; if (temperatura !== 32'h19051905) begin errors++; $display("FAIL scan_temperatura got %h exp 19051905", temperatura); end
    checks++; if (valido !== 2'b11 || erro_canal !== 2'b00) begin errors++; $display("FAIL scan_flags got %b/%b exp 11/00", valido, erro_canal); end
    checks++; if (npr !== 1) begin errors++; $display("FAIL scan_pronto got %0d exp 1", npr); end
    checks++; if (starts[0] - s0 !== 1 || starts[1] - s1 !== 1) begin errors++; $display("FAIL scan_starts got %0d/%0d exp 1/1", starts[0] - s0, starts[1] - s1); end
    @(negedge clock);
    checks++; if (pronto !== 1'b0) begin errors++; $display("FAIL scan_pronto_width got %b exp 0", pronto); end
  endtask

  task automatic test_retry();
    int s0, s1, npr;
    logic fin;
    dat[1] = 40'h40021A035F;
    bad_ate[0] = starts[0]; bad_ate[1] = starts[1] + 2;
    s0 = starts[0]; s1 = starts[1];
    run_scan(npr, fin);
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL retry_done got %b exp 1", fin); end
    checks++; if (starts[1] - s1 !== 3 || starts[0] - s0 !== 1) begin errors++; $display("FAIL retry_starts got %0d/%0d exp 1/3", starts[0] - s0, starts[1] - s1); end
    checks++; if (umidade !== 32'h40023700 || temperatura !== 32'h1A031905) begin errors++; $display("FAIL retry_data got %h/%h exp 40023700/1a031905", umidade, temperatura); end
    checks++; if (valido !== 2'b11 || erro_canal !== 2'b00) begin errors++; $display("FAIL retry_flags got %b/%b exp 11/00", valido, erro_canal); end
  endtask

  task automatic test_keep_on_fail();
    int npr;
    logic fin;
    silent[0] = 1'b1;
    dat[1] = 40'h41011B025F;
    bad_ate[0] = starts[0]; bad_ate[1] = starts[1];
    run_scan(npr, fin);
    silent[0] = 1'b0;
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL keep_done got %b exp 1", fin); end
    checks++; if (umidade !== 32'h41013700 || temperatura !== 32'h1B021905) begin errors++; $display("FAIL keep_data got %h/%h exp 41013700/1b021905", umidade, temperatura); end
    checks++; if (valido !== 2'b11 || erro_canal !== 2'b01) begin errors++; $display("FAIL keep_flags got %b/%b exp 11/01", valido, erro_canal); end
  endtask

  task automatic test_boundary();
    int s0, s1, npr;
    logic fin;
    hz0 = 8; hz1 = 9;
    dat[0] = 40'hA55A0FF0FE; dat[1] = 40'hA55A0FF0FE;
    bad_ate[0] = starts[0]; bad_ate[1] = starts[1];
    s0 = starts[0]; s1 = starts[1];
    run_scan(npr, fin);
    hz0 = 4; hz1 = 12;
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL bound_done got %b exp 1", fin); end
    checks++; if (umidade !== 32'hA55AA55A || temperatura !== 32'h0FF00FF0) begin errors++; $display("FAIL bound_data got %h/%h exp a55aa55a/0ff00ff0", umidade, temperatura); end
    checks++; if (valido !== 2'b11 || erro_canal !== 2'b00) begin errors++; $display("FAIL bound_flags got %b/%b exp 11/00", valido, erro_canal); end
    checks++; if (starts[0] - s0 !== 1 || starts[1] - s1 !== 1) begin errors++; $display("FAIL bound_starts got %0d/%0d exp 1/1", starts[0] - s0, starts[1] - s1); end
  endtask

  task automatic test_continuous();
    int rises [4];
    int nr, npr;
    logic po;
    dat[0] = 40'h3700190555; dat[1] = 40'h3700190555;
    bad_ate[0] = starts[0]; bad_ate[1] = starts[1];
    rises = '{0, 0, 0, 0};
    nr = 0; npr = 0;
    po = ocupado;
    modo_continuo = 1'b1;
    for (int k = 0; k < 8600; k++) begin
      @(negedge clock);
      if (medir) medir = 1'b0;
      if (pronto) npr++;
      if (ocupado && !po) begin
        if (nr < 4) rises[nr] = k;
        nr++;
        if (nr == 2) medir = 1'b1;
        if (nr == 3) modo_continuo = 1'b0;
      end
      po = ocupado;
    end
    checks++; if (nr !== 3) begin errors++; $display("FAIL cont_scans got %0d exp 3", nr); end
    checks++; if (rises[0] !== 1999) begin errors++; $display("FAIL cont_first got %0d exp 1999", rises[0]); end
    checks++; if (rises[1] - rises[0] !== 2000 || rises[2] - rises[1] !== 2000) begin errors++; $display("FAIL cont_period got %0d/%0d exp 2000/2000", rises[1] - rises[0], rises[2] - rises[1]); end
    checks++; if (npr !== 3) begin errors++; $display("FAIL cont_pronto got %0d exp 3", npr); end
    checks++; if (ocupado !== 1'b0 || db_estado !== 4'd0) begin errors++; $display("FAIL cont_idle got %b/%0d exp 0/0", ocupado, db_estado); end
  endtask

  task automatic test_reset_mid();
    logic found;
    int npr;
    // Reset while the host is driving its start pulse.
    found = 1'b0;
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (db_estado == 4'd2) begin found = 1'b1; break; end
      @(negedge clock);
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstA_reach got %b exp 1", found); end
    checks++; if (dht_bus[0] !== 1'b0) begin errors++; $display("FAIL rstA_drive got %b exp 0", dht_bus[0]); end
    abort = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if (dht_bus !== 2'b11) begin errors++; $display("FAIL rstA_release got %b exp 11", dht_bus); end
    checks++; if (db_estado !== 4'd0 || ocupado !== 1'b0) begin errors++; $display("FAIL rstA_state got %0d/%b exp 0/0", db_estado, ocupado); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    abort = 1'b0;
    // Re-load registers, then reset during a data bit of channel 0.
    test_scan_ok();
    found = 1'b0;
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (db_estado == 4'd7) begin found = 1'b1; break; end
      @(negedge clock);
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstB_reach got %b exp 1", found); end
    abort = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if ((dht_bus | drv) !== 2'b11) begin errors++; $display("FAIL rstB_release got %b exp 11", dht_bus | drv); end
    checks++; if (umidade !== 32'h0 || temperatura !== 32'h0) begin errors++; $display("FAIL rstB_data got %h/%h exp 0/0", umidade, temperatura); end
    checks++; if (valido !== 2'b00 || erro_canal !== 2'b00 || ocupado !== 1'b0 || pronto !== 1'b0) begin errors++; $display("FAIL rstB_flags got %b/%b/%b/%b exp 00/00/0/0", valido, erro_canal, ocupado, pronto); end
    checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL rstB_estado got %0d exp 0", db_estado); end
    repeat (10) @(negedge clock);
    checks++; if (dht_bus !== 2'b11) begin errors++; $display("FAIL rstB_bus_idle got %b exp 11", dht_bus); end
    reset = 1'b1;
    npr = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (pronto) npr++;
    end
    abort = 1'b0;
    checks++; if (npr !== 0 || db_estado !== 4'd0 || ocupado !== 1'b0) begin errors++; $display("FAIL rstB_after got %0d/%0d/%b exp 0/0/0", npr, db_estado, ocupado); end
  endtask

  initial begin
    dat[0] = 40'h3700190555;
    dat[1] = 40'h3700190555;
    test_reset();
    test_silent();
    test_scan_ok();
    test_retry();
    test_keep_on_fail();
    test_boundary();
    test_continuous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
